// File: rtl/prio_encoder_8to3_pkg.sv
// Shared definitions for the 8-lane priority / round-robin encoder.
//   N_REQ   : number of request lanes
//   IDX_W   : width of an encoded lane index
//   state_e : offer FSM encoding (IDLE, OFFER)
//   idx_to_onehot : expands an index into a single-bit lane mask
package prio_encoder_8to3_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/prio_encoder_8to3_decoder.sv
// 3-to-8 binary decoder with enable.
//   in  : binary index
//   en  : when low, out is all-zero
//   out : one-hot form of in
module decoder_3to8
  import prio_encoder_8to3_pkg::*;
(
  input  logic [IDX_W-1:0] in,
  input  logic             en,
  output logic [N_REQ-1:0] out
);

  assign out = en ? idx_to_onehot(in) : '0;

endmodule

// File: rtl/prio_encoder_8to3.sv
// Pending-request encoder: collects request pulses from 8 lanes into a
// pending register and offers one lane index at a time over a valid/ready
// handshake. Selection is round-robin (RR_EN = 1) or lowest-index-first.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : qualifies req_in
//   clear_in    : synchronous flush of all pending requests
//   req_in      : request pulses, one bit per lane
//   ready_in    : consumer accepts idx_out
//   valid_out   : idx_out holds a pending request index
//   idx_out     : offered lane index (stable while valid_out && !ready_in)
//   onehot_out  : decoded idx_out, zero when valid_out is low
//   pending_out : pending-bit register
//   overflow    : one-cycle pulse when a request lands on a pending bit
module prio_encoder_8to3
  import prio_encoder_8to3_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear_in,
  input  logic [N_REQ-1:0] req_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [IDX_W-1:0] idx_out,
  output logic [N_REQ-1:0] onehot_out,
  output logic [N_REQ-1:0] pending_out,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             ovf_q, ovf_d;

  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] served;
  logic             handshake;
  logic [IDX_W-1:0] start;

  // First set bit of c found when scanning upward from start with wrap.
  // Scanning offsets from high to low lets the smallest offset win.
  function automatic logic [IDX_W-1:0] select(input logic [N_REQ-1:0] c,
                                              input logic [IDX_W-1:0] from);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] j;
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = from + IDX_W'(i);
      if (c[j]) pick = j;
    end
    return pick;
  endfunction

  // NOTE: every signal written here gets a default first, so no path
  // through the block leaves a value held and no latch is inferred.
  always_comb begin
    req_eff   = en ? req_in : '0;
    handshake = (state_q == OFFER) && ready_in;
    served    = handshake ? idx_to_onehot(idx_q) : '0;
    pend_d    = (pend_q & ~served) | req_eff;
    // A re-request of the bit being served is not a collision.
    ovf_d     = |(req_eff & pend_q & ~served);
    ptr_d     = handshake ? idx_q + 1'b1 : ptr_q;
    // The next offer after a handshake searches from the updated pointer.
    start     = (RR_EN != 0) ? ptr_d : '0;
    state_d   = state_q;
    idx_d     = idx_q;

    unique case (state_q)
      IDLE: begin
        if (pend_d != '0) begin
          idx_d   = select(pend_d, start);
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (handshake) begin
          if (pend_d != '0) idx_d = select(pend_d, start);
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides both new requests and the handshake.
    if (clear_in) begin
      pend_d  = '0;
      state_d = IDLE;
      ovf_d   = 1'b0;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_out   = (state_q == OFFER);
  assign idx_out     = idx_q;
  assign pending_out = pend_q;
  assign overflow    = ovf_q;

  decoder_3to8 u_dec (
    .in  (idx_q),
    .en  (valid_out),
    .out (onehot_out)
  );

endmodule
